acc_bank: RTL and testbench
===========================

Name: acc_bank

Overview:
Parametrised multi-lane accumulator buffer that collects partial sums from the systolic array's column outputs.
- Each of LANES lanes owns DEPTH signed entries of DATA_W bits.
- Per-write mode selects overwrite or accumulate.
- A registered read port feeds the activation/writeback stage.
- A sequenced clear FSM zeroes the bank between tiles.

Parameters:
LANES, 4, number of parallel lanes (array columns)
DEPTH, 16, entries per lane (>=2, need not be a power of 2)
IN_W, 16, signed input width per lane (IN_W <= DATA_W)
DATA_W, 32, signed stored/accumulated width per lane
ADDR_W, derived localparam = max(1, clog2(DEPTH)); not overridable

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  write request
in_ready  output  1  1 when a write can be accepted (state IDLE)
in_mode  input  1  0 = overwrite, 1 = accumulate
in_addr  input  ADDR_W  entry index, shared by all lanes
in_lane_en  input  LANES  per-lane write enable mask
in_data  input  LANES*IN_W  lane i at bits [i*IN_W +: IN_W], signed
rd_en  input  1  read request
rd_addr  input  ADDR_W  read index
rd_valid  output  1  rd_data valid this cycle
rd_data  output  LANES*DATA_W  lane-packed read data
clear  input  1  start a full clear (sampled in IDLE only)
busy  output  1  clear in progress
drop_err  output  1  sticky: a write arrived while in_ready=0
sat_flag  output  1  sticky: a lane saturated (ACC_SAT_EN only)

Behaviour:
Reset:
- All entries = 0.
- rd_valid = 0, rd_data = 0, busy = 0, drop_err = 0, sat_flag = 0.
- FSM = IDLE; in_ready = 1 one cycle after reset deasserts.

Write (in_valid & in_ready at edge N):
- For each lane with in_lane_en[i]=1, mem[i][in_addr] updates at edge N.
- Overwrite: mem = sext(in_data_i).
- Accumulate: mem = mem + sext(in_data_i), signed, DATA_W wide.
- Back-to-back accumulates to the same address in consecutive cycles must all count; no lost updates.
- Lanes with in_lane_en=0 are unchanged.
- in_addr >= DEPTH: write ignored, no flag.
- Overflow: wraps mod 2^DATA_W unless ACC_SAT_EN is defined.

Read:
- rd_en at edge N gives rd_valid=1 and rd_data at N+1; latency 1. rd_valid=0 otherwise.
- rd_data holds its last value when rd_valid=0.
- Write and read to the same address in the same cycle: rd_data returns the post-write value (forwarded), per lane.
- rd_addr >= DEPTH: rd_valid=1, rd_data=0.
- Reads are allowed during CLEAR. Each entry returns its cleared (0) value once its clear cycle has passed, otherwise the old value.

Clear FSM (IDLE, CLEAR):
- IDLE -> CLEAR when clear=1. busy=1 and in_ready=0 from the next cycle.
- CLEAR zeroes all lanes of entry ptr each cycle, ptr = 0..DEPTH-1. Takes DEPTH cycles, then returns to IDLE; busy drops after the cycle that clears DEPTH-1.
- clear asserted while in CLEAR is ignored (no restart).
- in_valid while in_ready=0: write dropped, drop_err set. drop_err clears only on reset.
- Reset mid-clear: immediate IDLE, all entries 0, ptr = 0.

Optional Feature:
Macro ACC_SAT_EN.
- Defined: accumulate and overwrite results clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp on any enabled lane sets sat_flag (sticky until reset).
- Undefined: two's-complement wrap; sat_flag tied to 0.

Test Plan:
1. Reset, then overwrite addr 3 lane0 = 5 and lane1 = -2 (mask 4'b0011); rd_en addr 3 -> next cycle rd_valid=1, lane0=5, lane1=0xFFFFFFFE, lanes 2-3 = 0.
2. Accumulate addr 7 lane2 with +100, +100, -50 on three consecutive cycles -> read gives 150; same-cycle read with the third write returns 150.
3. clear with DEPTH=16 -> busy high exactly 16 cycles, in_ready=0; a write during busy sets drop_err=1 and addr 0 still reads 0 afterwards.
4. Assert reset at clear cycle 5 -> busy=0, in_ready=1 after release, all reads return 0.
5. DATA_W=32, entry = 0x7FFFFFFF, accumulate +1:
   - ACC_SAT_EN defined -> 0x7FFFFFFF and sat_flag=1.
   - ACC_SAT_EN undefined -> 0x80000000 and sat_flag=0.
6. DEPTH=12: write addr 13 -> no entry changes; read addr 13 -> rd_valid=1, rd_data=0.

Source files
------------

// File: rtl/acc_bank.sv
// acc_bank: multi-lane signed accumulator buffer for systolic-array partial sums.
// Each lane holds DEPTH entries of DATA_W bits. A write either overwrites or
// accumulates into an entry. A registered read port forwards same-cycle writes.
// A sequenced clear walks the bank one entry per cycle.
// Optional build macro: ACC_SAT_EN. When it is defined, results saturate and
// sat_flag latches. When it is undefined, results wrap and sat_flag stays 0.
module acc_bank #(
   parameter int  LANES  = 4,
   parameter int  DEPTH  = 16,
   parameter int  IN_W   = 16,
   parameter int  DATA_W = 32,
   localparam int ADDR_W = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_mode,
   input  logic [ADDR_W-1:0]       in_addr,
   input  logic [LANES-1:0]        in_lane_en,
   input  logic [LANES*IN_W-1:0]   in_data,
   input  logic                    rd_en,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic                    rd_valid,
   output logic [LANES*DATA_W-1:0] rd_data,
   input  logic                    clear,
   output logic                    busy,
   output logic                    drop_err,
   output logic                    sat_flag
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

   // One extra bit so that DEPTH itself is representable in the range compare.
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

   state_t                    state_q, state_d;
   logic [ADDR_W-1:0]         ptr_q, ptr_d;
   logic [DATA_W-1:0]         mem_q [LANES][DEPTH];
   logic [DATA_W-1:0]         mem_d [LANES][DEPTH];
   logic                      in_ready_q, in_ready_d;
   logic                      busy_q, busy_d;
   logic                      drop_err_q, drop_err_d;
   logic                      sat_q, sat_d;
   logic                      rd_valid_q, rd_valid_d;
   logic [LANES*DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                      wr_ok_s;
   logic                      wr_in_range_s;
   logic                      rd_in_range_s;

   // Sign-extend one lane of input data to the stored width.
   function automatic logic [DATA_W-1:0] sext_in(input logic [IN_W-1:0] x);
      return DATA_W'($signed(x));
   endfunction

`ifdef ACC_SAT_EN
   logic [DATA_W:0] wr_sum_s;

   // Compute the new entry value one bit wider, so overflow is visible.
   function automatic logic [DATA_W:0] wide_next(input logic mode,
                                                 input logic [DATA_W-1:0] old,
                                                 input logic [DATA_W-1:0] inc);
      if (mode) begin
         return {old[DATA_W-1], old} + {inc[DATA_W-1], inc};
      end else begin
         return {inc[DATA_W-1], inc};
      end
   endfunction

   // Detect overflow: the two top bits of the wide result differ.
   function automatic logic wide_ovf(input logic [DATA_W:0] s);
      return s[DATA_W] ^ s[DATA_W-1];
   endfunction

   // Clamp a wide result to the signed DATA_W range.
   function automatic logic [DATA_W-1:0] sat_clamp(input logic [DATA_W:0] s);
      if (s[DATA_W] == s[DATA_W-1]) begin
         return s[DATA_W-1:0];
      end else if (s[DATA_W]) begin
         return {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         return {1'b0, {(DATA_W-1){1'b1}}};
      end
   endfunction
`endif

   // Next state for the clear sequencer, the memory image and the sticky flags.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      mem_d         = mem_q;
      drop_err_d    = drop_err_q;
      sat_d         = sat_q;
`ifdef ACC_SAT_EN
      wr_sum_s      = '0;
`endif
      wr_ok_s       = in_valid & in_ready_q;
      wr_in_range_s = ({1'b0, in_addr} < DEPTH_EXT);
      case (state_q)
         ST_IDLE: begin
            ptr_d = '0;
            if (clear) begin
               state_d = ST_CLEAR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            for (int l = 0; l < LANES; l++) begin
               mem_d[l][ptr_q] = '0;
            end
            if (ptr_q == LAST_PTR) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               state_d = ST_CLEAR;
               ptr_d   = ptr_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      endcase
      if (in_valid && !in_ready_q) begin
         drop_err_d = 1'b1;
      end else begin
         drop_err_d = drop_err_q;
      end
      // Writes are accepted only in IDLE, so they never collide with a clear step.
      if (wr_ok_s && wr_in_range_s) begin
         for (int l = 0; l < LANES; l++) begin
            if (in_lane_en[l]) begin
`ifdef ACC_SAT_EN
               wr_sum_s = wide_next(in_mode, mem_q[l][in_addr],
                                    sext_in(in_data[l*IN_W +: IN_W]));
               mem_d[l][in_addr] = sat_clamp(wr_sum_s);
               if (wide_ovf(wr_sum_s)) begin
                  sat_d = 1'b1;
               end else begin
                  sat_d = sat_d;
               end
`else
               if (in_mode) begin
                  mem_d[l][in_addr] = mem_q[l][in_addr] + sext_in(in_data[l*IN_W +: IN_W]);
               end else begin
                  mem_d[l][in_addr] = sext_in(in_data[l*IN_W +: IN_W]);
               end
`endif
            end else begin
               mem_d[l][in_addr] = mem_q[l][in_addr];
            end
         end
      end else begin
         drop_err_d = drop_err_d;
      end
      in_ready_d = (state_d == ST_IDLE);
      busy_d     = (state_d == ST_CLEAR);
   end

   // Read port: sample the post-update image, so same-cycle writes and clears are forwarded.
   always_comb begin
      rd_valid_d    = rd_en;
      rd_data_d     = rd_data_q;
      rd_in_range_s = ({1'b0, rd_addr} < DEPTH_EXT);
      if (rd_en) begin
         if (rd_in_range_s) begin
            for (int l = 0; l < LANES; l++) begin
               rd_data_d[l*DATA_W +: DATA_W] = mem_d[l][rd_addr];
            end
         end else begin
            rd_data_d = '0;
         end
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   // State, memory and output registers; reset zeroes everything and parks in IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         drop_err_q <= 1'b0;
         sat_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         for (int l = 0; l < LANES; l++) begin
            for (int e = 0; e < DEPTH; e++) begin
               mem_q[l][e] <= '0;
            end
         end
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         drop_err_q <= drop_err_d;
         sat_q      <= sat_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         mem_q      <= mem_d;
      end
   end

   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign drop_err = drop_err_q;
   assign sat_flag = sat_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_acc_bank.sv
// Scoreboard bench for acc_bank.
// The main instance uses the default parameters. A second instance uses
// DEPTH=12 and DATA_W=16: it covers the non-power-of-2 depth and the
// overflow boundary within a few cycles.
module tb_acc_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          in_valid, in_ready, in_mode, rd_en, rd_valid, clear, busy, drop_err, sat_flag;
   logic [3:0]    in_addr, in_lane_en, rd_addr;
   logic [63:0]   in_data;
   logic [127:0]  rd_data;

   logic          b_in_valid, b_in_ready, b_in_mode, b_rd_en, b_rd_valid, b_clear, b_busy, b_drop_err, b_sat_flag;
   logic [3:0]    b_in_addr, b_in_lane_en, b_rd_addr;
   logic [63:0]   b_in_data;
   logic [63:0]   b_rd_data;

   int checks = 0;
   int errors = 0;
   int busy_cnt;
   logic [127:0] exp_q[$];
   logic [63:0]  exp12_q[$];

   acc_bank u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_addr(in_addr), .in_lane_en(in_lane_en), .in_data(in_data), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .clear(clear), .busy(busy),
      .drop_err(drop_err), .sat_flag(sat_flag)
   );

   acc_bank #(.LANES(4), .DEPTH(12), .IN_W(16), .DATA_W(16)) u_dut12 (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
      .in_addr(b_in_addr), .in_lane_en(b_in_lane_en), .in_data(b_in_data), .rd_en(b_rd_en),
      .rd_addr(b_rd_addr), .rd_valid(b_rd_valid), .rd_data(b_rd_data), .clear(b_clear), .busy(b_busy),
      .drop_err(b_drop_err), .sat_flag(b_sat_flag)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic m, input logic [3:0] a, input logic [3:0] msk,
                      input logic [63:0] d, input logic re, input logic [3:0] ra);
      in_valid = v; in_mode = m; in_addr = a; in_lane_en = msk; in_data = d;
      rd_en = re; rd_addr = ra; clear = 1'b0;
   endtask

   task automatic b_drv(input logic v, input logic m, input logic [3:0] a, input logic [3:0] msk,
                        input logic [63:0] d, input logic re, input logic [3:0] ra);
      b_in_valid = v; b_in_mode = m; b_in_addr = a; b_in_lane_en = msk; b_in_data = d;
      b_rd_en = re; b_rd_addr = ra; b_clear = 1'b0;
   endtask

   // Main read monitor: every rd_valid pops one expected word.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("rd_unexpected", 128'(rd_valid), 128'(1'b0));
         else chk("rd_data", rd_data, exp_q.pop_front());
      end
   end

   // Monitor for the DEPTH=12 instance.
   always @(negedge clk) begin
      if (b_rd_valid === 1'b1) begin
         if (exp12_q.size() == 0) chk("rd12_unexpected", 128'(b_rd_valid), 128'(1'b0));
         else chk("rd12_data", 128'(b_rd_data), 128'(exp12_q.pop_front()));
      end
   end

   initial begin
      reset = 1'b1;
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b0, 4'd0);
      b_drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b0, 4'd0);
      tick(); tick();
      chk("rst_rd_valid", 128'(rd_valid), 128'(1'b0));
      chk("rst_rd_data", rd_data, 128'd0);
      chk("rst_busy", 128'(busy), 128'(1'b0));
      chk("rst_drop_err", 128'(drop_err), 128'(1'b0));
      chk("rst_sat_flag", 128'(sat_flag), 128'(1'b0));
      reset = 1'b0;
      tick();
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));

      // 1: overwrite lanes 0/1 of addr 3; lanes 2/3 are masked off.
      drv(1'b1, 1'b0, 4'd3, 4'b0011, {16'h1234, 16'h1234, 16'hFFFE, 16'h0005}, 1'b0, 4'd0); tick();
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd3);
      exp_q.push_back({32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0005}); tick();

      // 2: back-to-back accumulates on lane 2; the third write is read in the same cycle.
      drv(1'b1, 1'b1, 4'd7, 4'b0100, {16'd0, 16'd100, 16'd0, 16'd0}, 1'b0, 4'd0); tick();
      drv(1'b1, 1'b1, 4'd7, 4'b0100, {16'd0, 16'd100, 16'd0, 16'd0}, 1'b0, 4'd0); tick();
      drv(1'b1, 1'b1, 4'd7, 4'b0100, {16'd0, 16'hFFCE, 16'd0, 16'd0}, 1'b1, 4'd7);
      exp_q.push_back({32'd0, 32'd150, 32'd0, 32'd0}); tick();
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd7);
      exp_q.push_back({32'd0, 32'd150, 32'd0, 32'd0}); tick();
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b0, 4'd0);
      chk("drop_err_quiet", 128'(drop_err), 128'(1'b0));

      // 3: full clear; a write is dropped during busy, and a re-clear is ignored.
      clear = 1'b1; tick();
      busy_cnt = 0;
      while (busy === 1'b1 && busy_cnt < 40) begin
         busy_cnt++;
         drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b0, 4'd0);
         if (busy_cnt == 1) begin
            chk("in_ready_busy", 128'(in_ready), 128'(1'b0));
            drv(1'b1, 1'b0, 4'd0, 4'b1111, {4{16'd9}}, 1'b0, 4'd0);
         end else if (busy_cnt == 3) begin
            clear = 1'b1;
         end else begin
            clear = 1'b0;
         end
         tick();
      end
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b0, 4'd0);
      chk("busy_cycles", 128'(busy_cnt), 128'(16));
      chk("drop_err_set", 128'(drop_err), 128'(1'b1));
      chk("in_ready_after_clear", 128'(in_ready), 128'(1'b1));
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd0); exp_q.push_back(128'd0); tick();
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd3); exp_q.push_back(128'd0); tick();
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd7); exp_q.push_back(128'd0); tick();

      // 4: reset in the middle of a clear.
      drv(1'b1, 1'b0, 4'd5, 4'b1000, {16'd77, 48'd0}, 1'b0, 4'd0); tick();
      drv(1'b1, 1'b0, 4'd15, 4'b0001, 64'd1, 1'b0, 4'd0); tick();
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd5);
      exp_q.push_back({32'd77, 96'd0}); tick();
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b0, 4'd0);
      clear = 1'b1; tick();
      clear = 1'b0;
      repeat (5) tick();
      chk("busy_mid_clear", 128'(busy), 128'(1'b1));
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_busy", 128'(busy), 128'(1'b0));
      chk("rst_mid_rd_valid", 128'(rd_valid), 128'(1'b0));
      @(posedge clk);
      #3 reset = 1'b0;
      tick();
      chk("rst_mid_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_mid_drop_err", 128'(drop_err), 128'(1'b0));
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd5); exp_q.push_back(128'd0); tick();
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd15); exp_q.push_back(128'd0); tick();
      drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b0, 4'd0);

      // 5: overflow boundary on the 16-bit instance (max + 1, then min - 1).
      b_drv(1'b1, 1'b0, 4'd2, 4'b0001, 64'h7FFF, 1'b0, 4'd0); tick();
      b_drv(1'b1, 1'b1, 4'd2, 4'b0001, 64'h0001, 1'b0, 4'd0); tick();
      b_drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd2);
`ifdef ACC_SAT_EN
      exp12_q.push_back({48'd0, 16'h7FFF}); tick();
      chk("sat_flag_pos", 128'(b_sat_flag), 128'(1'b1));
`else
      exp12_q.push_back({48'd0, 16'h8000}); tick();
      chk("sat_flag_pos", 128'(b_sat_flag), 128'(1'b0));
`endif
      b_drv(1'b1, 1'b0, 4'd4, 4'b0001, 64'h8000, 1'b0, 4'd0); tick();
      b_drv(1'b1, 1'b1, 4'd4, 4'b0001, 64'hFFFF, 1'b0, 4'd0); tick();
      b_drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd4);
`ifdef ACC_SAT_EN
      exp12_q.push_back({48'd0, 16'h8000}); tick();
`else
      exp12_q.push_back({48'd0, 16'h7FFF}); tick();
      chk("sat_flag_neg", 128'(b_sat_flag), 128'(1'b0));
`endif

      // 6: DEPTH=12: last valid entry works; addr 13 is neither stored nor aliased.
      b_drv(1'b1, 1'b0, 4'd11, 4'b0010, {16'd0, 16'd0, 16'd3, 16'd0}, 1'b0, 4'd0); tick();
      b_drv(1'b1, 1'b0, 4'd13, 4'b1111, {4{16'h5555}}, 1'b0, 4'd0); tick();
      b_drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd13); exp12_q.push_back(64'd0); tick();
      b_drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd11);
      exp12_q.push_back({16'd0, 16'd0, 16'd3, 16'd0}); tick();
      b_drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd1); exp12_q.push_back(64'd0); tick();
      b_drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b1, 4'd5); exp12_q.push_back(64'd0); tick();
      b_drv(1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 1'b0, 4'd0);
      chk("b_drop_err", 128'(b_drop_err), 128'(1'b0));

      repeat (3) tick();
      chk("sb_empty", 128'(exp_q.size()), 128'(0));
      chk("sb12_empty", 128'(exp12_q.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
